// File: rtl/qs_dma_pkg.sv
// qs_dma_pkg: shared encodings for the Qsort multi-channel DMA.
//   - dma_state_e : top-level transfer FSM states
//   - REG_*       : word index of each register in the Wishbone window
//   - CTRL_*      : bit positions inside the CTRL register
package qs_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ABORT = 2'd2,
      DONE  = 2'd3
   } dma_state_e;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_SRC  = 2'd1;
   localparam logic [1:0] REG_DST  = 2'd2;
   localparam logic [1:0] REG_LEN  = 2'd3;

   // write side of CTRL
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   // read side of CTRL
   localparam int CTRL_BUSY  = 0;
   localparam int CTRL_DONE  = 1;

endpackage

// File: rtl/qs_sync_fifo.sv
// qs_sync_fifo: single-clock FIFO, DEPTH a power of 2 (>= 2).
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all contents (pointers and count to zero)
//   push, din  : write side
//   pop, dout  : read side, dout is the current head
//   full, empty, count : occupancy status
// Push+pop together is legal when full (both happen) and when empty
// (the pushed word passes straight through dout and occupancy stays 0).
module qs_sync_fifo
#(
   parameter int DW    = 32,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [DW-1:0]            din,
   input  logic                     pop,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = empty ? din : mem[rptr];

   // On empty, push+pop is a pass-through: neither pointer moves.
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~(empty & pop) & (~full | pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qs_dma_mc.sv
// qs_dma_mc: two-channel DMA between SDRAM (via arbiter) and a stream engine.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs_*              : Wishbone slave, 4-word register window at BASE_ADDR
//                        (CTRL, SRC, DST, LEN)
//   dma_*              : Wishbone-style master toward the SDRAM arbiter,
//                        one transaction outstanding at a time
//   ss_*               : read stream out (words fetched from SRC)
//   sm_*               : write stream in (words stored to DST)
module qs_dma_mc
   import qs_dma_pkg::*;
#(
   parameter int              DW        = 32,
   parameter int              AW        = 32,
   parameter logic [AW-1:0]   BASE_ADDR = 32'h3000_0080,
   parameter int              RD_DEPTH  = 4,
   parameter int              WR_DEPTH  = 4,
   parameter int              LEN_W     = 16
)(
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [AW-1:0]   wbs_adr_i,
   input  logic [DW-1:0]   wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [DW-1:0]   wbs_dat_o,
   output logic            dma_stb_i,
   output logic            dma_cyc_i,
   output logic            dma_we_i,
   output logic [3:0]      dma_sel_i,
   output logic [AW-1:0]   dma_adr_i,
   output logic [DW-1:0]   dma_dat_i,
   input  logic            dma_ack_o,
   input  logic [DW-1:0]   dma_dat_o,
   output logic            ss_tvalid,
   output logic [DW-1:0]   ss_tdata,
   input  logic            ss_tready,
   input  logic            sm_tvalid,
   input  logic [DW-1:0]   sm_tdata,
   output logic            sm_tready
);

   localparam int RCW = $clog2(RD_DEPTH) + 1;
   localparam int WCW = $clog2(WR_DEPTH) + 1;

   dma_state_e       state, state_nxt;
   logic [AW-1:0]    src, dst;
   logic [LEN_W-1:0] len, rd_cnt, wr_cnt, rd_idx, wr_idx, acc_cnt;
   logic             done, busy;

   logic             hit, wr_hit, start_req, abort_req;
   logic [1:0]       reg_idx;
   logic [DW-1:0]    rd_data;

   logic             cur_rd;        // outstanding transaction is a read
   logic             gnt_last_rd;   // last grant went to the read channel
   logic             rd_elig, wr_elig, issue_rd, issue_wr;
   logic             ack_rd, ack_wr, flush;

   logic             rd_full, rd_empty, wr_full, wr_empty;
   logic [RCW-1:0]   rd_count;
   logic [WCW-1:0]   wr_count;
   logic [DW-1:0]    wr_head;
   logic             sm_push;

   logic             unused_bits;
   assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wr_count, rd_full};

   // ---------------- slave decode ----------------
   assign reg_idx   = wbs_adr_i[3:2];
   assign hit       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o
                    & (wbs_adr_i[AW-1:4] == BASE_ADDR[AW-1:4]);
   assign wr_hit    = hit & wbs_we_i;
   assign start_req = wr_hit & (reg_idx == REG_CTRL) & wbs_dat_i[CTRL_START];
   assign abort_req = wr_hit & (reg_idx == REG_CTRL) & wbs_dat_i[CTRL_ABORT];
   assign busy      = (state != IDLE);

   always_comb begin
      rd_data = '0;
      case (reg_idx)
         REG_CTRL: begin
            rd_data[CTRL_BUSY] = busy;
            rd_data[CTRL_DONE] = done;
         end
         REG_SRC: rd_data = DW'(src);
         REG_DST: rd_data = DW'(dst);
         default: rd_data = DW'(len);
      endcase
   end

   // ---------------- arbitration ----------------
   // Occupancy counts the in-flight read so an ack can never overflow the FIFO.
   assign rd_elig  = (rd_cnt != '0) &&
                     ((int'(rd_count) + int'(dma_stb_i & cur_rd)) < RD_DEPTH);
   assign wr_elig  = ~wr_empty;
   assign issue_rd = rd_elig & (~wr_elig | ~gnt_last_rd);
   assign issue_wr = wr_elig & ~issue_rd;

   assign ack_rd   = dma_stb_i & dma_ack_o & cur_rd;
   assign ack_wr   = dma_stb_i & dma_ack_o & ~cur_rd;

   // ---------------- streams ----------------
   assign ss_tvalid = ~rd_empty;
   assign sm_tready = (state == RUN) & ~wr_full & (acc_cnt < len);
   assign sm_push   = sm_tvalid & sm_tready;

   assign dma_cyc_i = dma_stb_i;
   assign dma_sel_i = 4'hF;

   // ---------------- FSM ----------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      unique case (state)
         IDLE:  if (start_req) state_nxt = (len == '0) ? DONE : RUN;
         RUN: begin
            if (abort_req)                         state_nxt = ABORT;
            else if (wr_cnt == '0 && !dma_stb_i)   state_nxt = DONE;
         end
         ABORT: begin
            // drain the outstanding transaction before dropping the FIFOs
            if (!dma_stb_i) begin
               flush     = 1'b1;
               state_nxt = IDLE;
            end
         end
         DONE:  state_nxt = IDLE;
      endcase
   end

   // ---------------- registers and master port ----------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o   <= 1'b0;
         wbs_dat_o   <= '0;
         src         <= '0;
         dst         <= '0;
         len         <= '0;
         done        <= 1'b0;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
         rd_idx      <= '0;
         wr_idx      <= '0;
         acc_cnt     <= '0;
         dma_stb_i   <= 1'b0;
         dma_we_i    <= 1'b0;
         dma_adr_i   <= '0;
         dma_dat_i   <= '0;
         cur_rd      <= 1'b0;
         gnt_last_rd <= 1'b0;
      end else begin
         wbs_ack_o <= hit;
         wbs_dat_o <= (hit && !wbs_we_i) ? rd_data : '0;

         if (wr_hit && !busy) begin
            case (reg_idx)
               REG_SRC: src <= AW'(wbs_dat_i);
               REG_DST: dst <= AW'(wbs_dat_i);
               REG_LEN: len <= wbs_dat_i[LEN_W-1:0];
               default: ;
            endcase
         end

         if (state == IDLE && start_req) begin
            done    <= 1'b0;
            rd_cnt  <= len;
            wr_cnt  <= len;
            rd_idx  <= '0;
            wr_idx  <= '0;
            acc_cnt <= '0;
         end
         if (state == DONE) done <= 1'b1;

         if (sm_push) acc_cnt <= acc_cnt + 1'b1;

         if (dma_stb_i) begin
            if (dma_ack_o) begin
               dma_stb_i <= 1'b0;
               dma_we_i  <= 1'b0;
               if (cur_rd) begin
                  rd_cnt <= rd_cnt - 1'b1;
                  rd_idx <= rd_idx + 1'b1;
               end else begin
                  wr_cnt <= wr_cnt - 1'b1;
                  wr_idx <= wr_idx + 1'b1;
               end
            end
         end else if (state == RUN && (issue_rd || issue_wr)) begin
            dma_stb_i   <= 1'b1;
            dma_we_i    <= issue_wr;
            cur_rd      <= issue_rd;
            gnt_last_rd <= issue_rd;
            dma_adr_i   <= issue_rd ? src + (AW'(rd_idx) << 2)
                                    : dst + (AW'(wr_idx) << 2);
            dma_dat_i   <= issue_rd ? '0 : wr_head;
         end
      end
   end

   // ---------------- FIFOs ----------------
   qs_sync_fifo #(.DW(DW), .DEPTH(RD_DEPTH)) u_rd_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .flush (flush),
      .push  (ack_rd),
      .din   (dma_dat_o),
      .pop   (ss_tvalid & ss_tready),
      .dout  (ss_tdata),
      .full  (rd_full),
      .empty (rd_empty),
      .count (rd_count)
   );

   qs_sync_fifo #(.DW(DW), .DEPTH(WR_DEPTH)) u_wr_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .flush (flush),
      .push  (sm_push),
      .din   (sm_tdata),
      .pop   (ack_wr),
      .dout  (wr_head),
      .full  (wr_full),
      .empty (wr_empty),
      .count (wr_count)
   );

endmodule

// File: tb/tb_qs_dma_mc.sv
// Directed bench for qs_dma_mc with an SDRAM responder, a stream engine
// model and scoreboards for read addresses, write address/data and ss data.
module tb_qs_dma_mc;

   localparam logic [31:0] BASE = 32'h3000_0080;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_stb_i = 0, wbs_cyc_i = 0, wbs_we_i = 0;
   logic [3:0]  wbs_sel_i = 4'hF;
   logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        dma_stb_i, dma_cyc_i, dma_we_i;
   logic [3:0]  dma_sel_i;
   logic [31:0] dma_adr_i, dma_dat_i;
   logic        dma_ack_o = 0;
   logic [31:0] dma_dat_o = 0;
   logic        ss_tvalid, ss_tready = 0;
   logic [31:0] ss_tdata;
   logic        sm_tvalid = 0, sm_tready;
   logic [31:0] sm_tdata = 0;

   always #5 clk = ~clk;

   qs_dma_mc dut (
      .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .dma_stb_i(dma_stb_i), .dma_cyc_i(dma_cyc_i), .dma_we_i(dma_we_i),
      .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
      .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tready(sm_tready)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // scoreboards
   logic [31:0] exp_rd_q[$];
   logic [31:0] exp_wa_q[$];
   logic [31:0] exp_wd_q[$];
   logic [31:0] exp_ss_q[$];
   logic [31:0] sm_q[$];
   bit          gnt_log[$];

   int  ack_dly = 3;
   int  dly_cnt = 0;
   int  n_rd_ack = 0, n_wr_ack = 0;
   int  stb_cycles = 0, smr_cycles = 0;
   logic [31:0] held_adr, held_dat;
   bit  rdy_en = 0, echo_en = 0;

   // SDRAM responder: ack on the ack_dly-th cycle of a request
   always @(negedge clk) begin
      dma_ack_o = 1'b0;
      if (dma_stb_i) stb_cycles++;
      if (sm_tready) smr_cycles++;
      if (dma_stb_i && !wb_rst_i) begin
         dly_cnt++;
         if (dly_cnt == 1) begin
            held_adr = dma_adr_i;
            held_dat = dma_dat_i;
         end else begin
            check("dma_hold_adr", dma_adr_i, held_adr);
            check("dma_hold_dat", dma_dat_i, held_dat);
         end
         if (dly_cnt >= ack_dly) begin
            dly_cnt   = 0;
            dma_ack_o = 1'b1;
            gnt_log.push_back(dma_we_i);
            if (dma_we_i) begin
               n_wr_ack++;
               check("wr_q_nonempty", exp_wa_q.size() != 0, 1);
               if (exp_wa_q.size() != 0) begin
                  check("wr_adr", dma_adr_i, exp_wa_q.pop_front());
                  check("wr_dat", dma_dat_i, exp_wd_q.pop_front());
               end
            end else begin
               n_rd_ack++;
               dma_dat_o = mem_f(dma_adr_i);
               check("rd_q_nonempty", exp_rd_q.size() != 0, 1);
               if (exp_rd_q.size() != 0) check("rd_adr", dma_adr_i, exp_rd_q.pop_front());
            end
         end
      end else begin
         dly_cnt = 0;
      end
   end

   // stream engine: consumes ss (optionally echoing to sm), feeds sm from sm_q
   always @(negedge clk) begin
      sm_tvalid = (sm_q.size() != 0);
      sm_tdata  = sm_tvalid ? sm_q[0] : 32'h0;
      if (sm_tvalid && sm_tready) void'(sm_q.pop_front());
      ss_tready = rdy_en;
      if (ss_tvalid && ss_tready) begin
         check("ss_q_nonempty", exp_ss_q.size() != 0, 1);
         if (exp_ss_q.size() != 0) check("ss_data", ss_tdata, exp_ss_q.pop_front());
         if (echo_en) sm_q.push_back(ss_tdata);
      end
   end

   task automatic wb_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, output logic [31:0] rdat);
      @(negedge clk);
      check("wb_ack_pre", wbs_ack_o, 0);
      wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
      @(posedge clk);
      @(negedge clk);
      check("wb_ack", wbs_ack_o, 1);
      rdat = wbs_dat_o;
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
   endtask

   task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] r;
      wb_xfer(1'b1, adr, dat, r);
   endtask

   task automatic wb_rd(input logic [31:0] adr, output logic [31:0] dat);
      wb_xfer(1'b0, adr, 32'h0, dat);
   endtask

   task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                             input int n, input bit exp_wr);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = s + 32'(4 * i);
         exp_rd_q.push_back(a);
         exp_ss_q.push_back(mem_f(a));
         if (exp_wr) begin
            exp_wa_q.push_back(d + 32'(4 * i));
            exp_wd_q.push_back(mem_f(a));
         end
      end
      wb_wr(BASE + 4, s);
      wb_wr(BASE + 8, d);
      wb_wr(BASE + 12, 32'(n));
      wb_wr(BASE, 32'h1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic [31:0] r;
      int n;
      n = 0;
      do begin
         wb_rd(BASE, r);
         n++;
      end while (r[0] && n < budget);
      check(tag, r, 32'h2);
   endtask

   task automatic check_queues(input string tag);
      check({tag, "_rdq"}, exp_rd_q.size(), 0);
      check({tag, "_wrq"}, exp_wa_q.size(), 0);
      check({tag, "_ssq"}, exp_ss_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ack"},  wbs_ack_o, 0);
      check({tag, "_wdat"}, wbs_dat_o, 0);
      check({tag, "_stb"},  dma_stb_i, 0);
      check({tag, "_cyc"},  dma_cyc_i, 0);
      check({tag, "_we"},   dma_we_i, 0);
      check({tag, "_sel"},  dma_sel_i, 4'hF);
      check({tag, "_adr"},  dma_adr_i, 0);
      check({tag, "_dat"},  dma_dat_i, 0);
      check({tag, "_ssv"},  ss_tvalid, 0);
      check({tag, "_smr"},  sm_tready, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int s0, m0, k;

      // ---- reset state
      repeat (3) @(negedge clk);
      check_reset("rst");
      wb_rst_i = 0;
      wb_rd(BASE, r);
      check("ctrl_after_rst", r, 0);

      // ---- addresses outside the window are never acked
      @(negedge clk);
      wbs_stb_i = 1; wbs_cyc_i = 1; wbs_adr_i = BASE + 32'h10;
      repeat (3) begin
         @(negedge clk);
         check("oow_noack", wbs_ack_o, 0);
      end
      wbs_stb_i = 0; wbs_cyc_i = 0;

      // ---- 1: basic copy with echo
      rdy_en = 1; echo_en = 1; n_rd_ack = 0; n_wr_ack = 0;
      start_xfer(32'h3800_0000, 32'h3800_0100, 10, 1);
      wait_idle("t1_done", 500);
      check_queues("t1");
      check("t1_nrd", n_rd_ack, 10);
      check("t1_nwr", n_wr_ack, 10);
      wb_rd(BASE + 4, r);
      check("t1_src_rb", r, 32'h3800_0000);

      // ---- 2 + 6: back-pressure and register access while busy
      rdy_en = 0; echo_en = 0; n_rd_ack = 0;
      start_xfer(32'h3800_0200, 32'h3800_0300, 10, 1);
      wb_wr(BASE + 12, 32'd99);
      wb_rd(BASE + 12, r);
      check("t6_len_kept", r, 10);
      @(negedge clk);
      check("t6_ack_1cyc", wbs_ack_o, 0);
      check("t6_dat_idle", wbs_dat_o, 0);
      wb_rd(BASE, r);
      check("t6_ctrl_busy", r, 32'h1);
      repeat (40) @(negedge clk);
      s0 = stb_cycles;
      repeat (20) @(negedge clk);
      check("t2_nrd_stall", n_rd_ack, 4);
      check("t2_stb_quiet", stb_cycles - s0, 0);
      rdy_en = 1; echo_en = 1;
      wait_idle("t2_done", 500);
      check_queues("t2");

      // ---- 3: arbitration with both channels eligible
      rdy_en = 0; echo_en = 0; gnt_log.delete();
      for (int i = 0; i < 6; i++) begin
         sm_q.push_back(32'hC0DE_0000 + 32'(i));
         exp_wa_q.push_back(32'h3800_0700 + 32'(4 * i));
         exp_wd_q.push_back(32'hC0DE_0000 + 32'(i));
      end
      start_xfer(32'h3800_0600, 32'h3800_0700, 6, 0);
      k = 0;
      while (gnt_log.size() < 6 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("t3_grants_seen", gnt_log.size() >= 6, 1);
      for (int i = 0; i < 6; i++) check($sformatf("t3_gnt%0d", i), gnt_log[i], i % 2);
      rdy_en = 1;
      wait_idle("t3_done", 500);
      check_queues("t3");

      // ---- 4: LEN = 0
      s0 = stb_cycles; m0 = smr_cycles;
      wb_wr(BASE + 12, 32'd0);
      wb_wr(BASE, 32'h1);
      wb_rd(BASE, r);
      check("t4_done", r, 32'h2);
      repeat (4) @(negedge clk);
      check("t4_no_stb", stb_cycles - s0, 0);
      check("t4_no_smr", smr_cycles - m0, 0);

      // ---- 5: abort during an outstanding read
      ack_dly = 6; rdy_en = 0; echo_en = 0; n_rd_ack = 0;
      start_xfer(32'h3800_0400, 32'h3800_0500, 4, 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!dma_stb_i && k < 50);
      check("t5_stb_seen", dma_stb_i, 1);
      wb_wr(BASE, 32'h2);
      check("t5_stb_held", dma_stb_i, 1);
      k = 0;
      do begin @(negedge clk); k++; end while (dma_stb_i && k < 50);
      check("t5_stb_drop", dma_stb_i, 0);
      repeat (3) @(negedge clk);
      wb_rd(BASE, r);
      check("t5_ctrl_idle", r, 0);
      check("t5_ss_empty", ss_tvalid, 0);
      check("t5_smr", sm_tready, 0);
      check("t5_nrd", n_rd_ack, 1);
      exp_rd_q.delete(); exp_ss_q.delete();
      ack_dly = 3;

      // ---- 7: reset mid-transfer
      rdy_en = 1; echo_en = 1; n_rd_ack = 0;
      start_xfer(32'h3800_0800, 32'h3800_0900, 10, 1);
      k = 0;
      while (n_rd_ack < 3 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("t7_progress", n_rd_ack >= 3, 1);
      wb_rst_i = 1;
      @(negedge clk);
      check_reset("t7");
      echo_en = 0;
      sm_q.delete(); exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete(); exp_ss_q.delete();
      wb_rst_i = 0;
      wb_rd(BASE, r);
      check("t7_ctrl", r, 0);
      wb_rd(BASE + 12, r);
      check("t7_len", r, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/qs_dma_mc.md
Name: qs_dma_mc

Overview:
- Parametrised successor to the Qsort DMA. Moves a programmable number of 32-bit words between SDRAM and a stream engine.
- Read channel: fetches LEN words from SRC and presents them on ss_* through a read FIFO.
- Write channel: accepts words on sm_* into a write FIFO and stores them to DST.
- Sits between the Caravel Wishbone bus (slave, configuration) and the SDRAM arbiter (master, dma_* port). The two channels share the master port under round-robin arbitration.

Parameters:
- BASE_ADDR, 32'h30000080, base of the 4-word register window.
- DW, 32, data width of the bus and the streams.
- AW, 32, address width.
- RD_DEPTH, 4, read FIFO depth (power of 2, at least 2).
- WR_DEPTH, 4, write FIFO depth (power of 2, at least 2).
- LEN_W, 16, width of the word-count register.

Ports:
- wb_clk_i in 1: the single clock.
- wb_rst_i in 1: synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i in 1: Wishbone slave strobe, cycle, write enable.
- wbs_sel_i in 4: byte select (ignored; full-word access only).
- wbs_adr_i in AW, wbs_dat_i in DW: slave address and write data.
- wbs_ack_o out 1, wbs_dat_o out DW: slave acknowledge and read data.
- dma_stb_i, dma_cyc_i, dma_we_i out 1: master request to the arbiter.
- dma_sel_i out 4: always 4'hF.
- dma_adr_i out AW, dma_dat_i out DW: master address and write data.
- dma_ack_o in 1, dma_dat_o in DW: arbiter acknowledge and read data.
- ss_tvalid out 1, ss_tdata out DW, ss_tready in 1: read stream toward the engine.
- sm_tvalid in 1, sm_tdata in DW, sm_tready out 1: write stream from the engine.

Behaviour:
- Register map (word offsets from BASE_ADDR):
  - 0x0 CTRL: W bit0 = start, W bit1 = abort; R bit0 = busy, R bit1 = done.
  - 0x4 SRC.
  - 0x8 DST.
  - 0xC LEN, in words, LEN_W bits, zero-extended on read.
- Slave decode: hit = stb & cyc & address in window & !wbs_ack_o. wbs_ack_o asserts exactly 1 cycle after a hit, for 1 cycle. wbs_dat_o is valid with the ack and 0 otherwise. Addresses outside the window get no ack.
- Writes to SRC, DST and LEN while busy are acked and ignored. Start while busy is ignored.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, all dma_* outputs 0 except dma_sel_i=4'hF, ss_tvalid=0, sm_tready=0. Registers, counters and FIFOs are cleared; state is IDLE.
- Top FSM:
  - IDLE: on start, clear done, load rd_cnt=wr_cnt=LEN and zero the address offsets. Go to RUN, or to DONE the next cycle if LEN=0.
  - RUN: go to DONE when wr_cnt reaches 0 and no transaction is outstanding.
  - ABORT: entered on an abort write during RUN. Wait for any outstanding dma_ack_o, flush both FIFOs, go to IDLE with done=0.
  - DONE: set done (sticky until the next start) and return to IDLE the next cycle.
  - busy = (state != IDLE).
- Master port: one transaction outstanding at a time. stb, cyc, we, adr and dat are held stable from issue until dma_ack_o. Deassert the cycle after the ack; the next issue is allowed one cycle later.
- Read request is eligible when: rd_cnt>0, and rd FIFO occupancy plus in-flight reads < RD_DEPTH. Address = SRC + 4*rd_idx.
- Write request is eligible when: wr FIFO is non-empty. Address = DST + 4*wr_idx; data = wr FIFO head.
- Arbitration: if both requests are eligible, the channel not granted last wins. The grant-last flag resets to write, so read goes first.
- Read ack: push dma_dat_o into the rd FIFO, decrement rd_cnt.
- Write ack: pop the wr FIFO, decrement wr_cnt.
- Streams:
  - ss_tvalid = rd FIFO non-empty; ss_tdata = rd FIFO head; pop on ss_tvalid & ss_tready.
  - sm_tready = RUN & wr FIFO not full & (accepted words < LEN). sm words beyond LEN are never accepted.
  - A push and a pop in the same cycle on a full or empty FIFO are both legal. Occupancy is then unchanged and the data ordering is preserved.
- Address arithmetic: AW-bit modulo; no 1 KB boundary check.
- Reset mid-transfer: everything is cleared on the next edge. A pending arbiter ack after reset is ignored because stb is already low.

Decomposition:
- Package qs_dma_pkg holds:
  - State encodings: IDLE, RUN, ABORT, DONE.
  - Register offsets: CTRL=0, SRC=1, DST=2, LEN=3 (word index).
  - CTRL bit positions.
- One sub-module, qs_sync_fifo (parameters DW and DEPTH; ports push, pop, full, empty, count), instantiated twice: rd FIFO and wr FIFO.

Test Plan:
1. Basic copy:
   - Stimulus: SRC=0x3800_0000, DST=0x3800_0100, LEN=10, start; SDRAM model acks after 3 cycles; engine echoes each ss word to sm.
   - Required: 10 reads at 0x3800_0000..0x3800_0024, 10 writes at 0x3800_0100..0x3800_0124 with matching data, then done=1 and busy=0.
2. Back-pressure:
   - Stimulus: ss_tready held 0 with RD_DEPTH=4, LEN=10.
   - Required: exactly 4 read transactions, then dma_stb_i stays 0. Releasing ss_tready resumes reads; no data lost or reordered.
3. Arbitration:
   - Stimulus: read and write both eligible for 6 consecutive grants.
   - Required: grants alternate R, W, R, W, R, W.
4. LEN=0 start:
   - Required: no dma_stb_i activity, done=1 within 2 cycles, sm_tready stays 0.
5. Abort:
   - Stimulus: abort written during an outstanding read, ack delayed 5 cycles.
   - Required: stb held until the ack, then IDLE with both FIFOs empty, ss_tvalid=0, done=0.
6. Register access:
   - Stimulus: LEN write while busy; read of CTRL.
   - Required: ack 1 cycle after the hit, LEN unchanged, CTRL read returns 0x1 while busy.
7. Reset mid-transfer:
   - Stimulus: wb_rst_i asserted mid-transfer.
   - Required: all outputs at their reset values on the next edge.
